// File: rtl/razr_scale_pipe.sv
// Two-stage signed scale/round/saturate pipeline with valid/ready handshake and sticky overflow counter.
// Build option: define RAZR_ROUND_EN for round-half-up before the shift; otherwise plain truncation.
module razr_scale_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 12,
    parameter int SH_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic [SH_W-1:0]  in_shift,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam int SHC_W  = (IN_W > 2) ? $clog2(IN_W) : 1;
    localparam int MAX_SH = IN_W - 1;

    logic                    s1_v;
    logic signed [IN_W:0]    s1_r;
    logic                    s2_v;
    logic                    adv1;
    logic                    adv2;
    logic                    in_xfer;
    logic                    out_xfer;

    logic [SHC_W-1:0]        sh;
    logic signed [IN_W:0]    t;
    logic signed [IN_W:0]    r;

    logic [IN_W-OUT_W:0]     hi_bits;
    logic [OUT_W-1:0]        sat_data;
    logic                    sat_ovf;

    // Handshake: ready depends only on valid bits and out_ready
    always_comb begin
        adv2     = !s2_v || out_ready;
        adv1     = !s1_v || adv2;
        in_ready = adv1;
        in_xfer  = in_valid && adv1;
        out_xfer = s2_v && out_ready;
    end

    assign out_valid = s2_v;

    // Stage 1: clamp shift amount, optionally bias, arithmetic shift
    always_comb begin
        sh = '0;
        if (32'(in_shift) > 32'(MAX_SH)) begin
            sh = SHC_W'(MAX_SH);
        end else begin
            sh = SHC_W'(in_shift);
        end
    end

`ifdef RAZR_ROUND_EN
    logic signed [IN_W:0] bias;

    always_comb begin
        bias = '0;
        if (sh != '0) begin
            bias = (IN_W+1)'(1) << (sh - SHC_W'(1));
        end
        t = $signed({in_data[IN_W-1], in_data}) + bias;
        r = t >>> sh;
    end
`else
    always_comb begin
        t = $signed({in_data[IN_W-1], in_data});
        r = t >>> sh;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_r <= '0;
        end else if (adv1) begin
            s1_v <= in_xfer;
            s1_r <= r;
        end
    end

    // Stage 2: value fits iff all bits above the output sign bit match it
    always_comb begin
        hi_bits  = s1_r[IN_W:OUT_W-1];
        sat_data = s1_r[OUT_W-1:0];
        sat_ovf  = 1'b0;
        if (!((hi_bits == '0) || (hi_bits == '1))) begin
            sat_ovf = 1'b1;
            if (s1_r[IN_W]) begin
                sat_data = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                sat_data = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v     <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (adv2) begin
            s2_v     <= s1_v;
            out_data <= sat_data;
            out_ovf  <= sat_ovf;
        end
    end

    // Clear wins over a same-cycle increment; count sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (cnt_clr) begin
            ovf_cnt <= '0;
        end else if (out_xfer && out_ovf && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_razr_scale_pipe.sv
// Self-checking bench for razr_scale_pipe: arithmetic reference model + scoreboard, plus directed literal vectors.
module tb_razr_scale_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 12;
    localparam int SH_W  = 4;
    localparam int CNT_W = 16;
`ifdef RAZR_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [IN_W-1:0]  in_data;
    logic [SH_W-1:0]  in_shift;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;
    logic             cnt_clr;
    logic [CNT_W-1:0] ovf_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [OUT_W:0]   q[$];
    logic [CNT_W-1:0] mcnt;

    razr_scale_pipe #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SH_W (SH_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_shift (in_shift),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .cnt_clr  (cnt_clr),
        .ovf_cnt  (ovf_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: exact integer arithmetic, returns {ovf, data}
    function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] d, input logic [SH_W-1:0] s);
        longint v;
        longint lim_hi;
        longint lim_lo;
        int     sh;
        v      = longint'($signed(d));
        sh     = (int'(s) > IN_W - 1) ? IN_W - 1 : int'(s);
        if (RND && sh > 0) v = v + (longint'(1) << (sh - 1));
        v      = v >>> sh;
        lim_hi = (longint'(1) << (OUT_W - 1)) - 1;
        lim_lo = -(longint'(1) << (OUT_W - 1));
        if (v > lim_hi) return {1'b1, lim_hi[OUT_W-1:0]};
        if (v < lim_lo) return {1'b1, lim_lo[OUT_W-1:0]};
        return {1'b0, v[OUT_W-1:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [OUT_W:0]   e;
        logic             got;
        logic             stall;
        logic [OUT_W-1:0] prev_data;
        logic             prev_ovf;
        stall     = 1'b0;
        prev_data = '0;
        prev_ovf  = 1'b0;
        mcnt      = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                mcnt  = '0;
                stall = 1'b0;
                chk("rst_out_valid", 64'(out_valid), 64'(0));
                chk("rst_in_ready", 64'(in_ready), 64'(1));
            end else begin
                chk("ovf_cnt", 64'(ovf_cnt), 64'(mcnt));
                chk("in_ready", 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
                if (out_valid) chk("valid_has_beat", 64'(q.size() > 0), 64'(1));
                if (stall) begin
                    chk("stall_data", 64'(out_data), 64'(prev_data));
                    chk("stall_ovf", 64'(out_ovf), 64'(prev_ovf));
                end
                got = 1'b0;
                e   = '0;
                if (out_valid && out_ready && q.size() > 0) begin
                    e   = q.pop_front();
                    got = 1'b1;
                    chk("out_data", 64'(out_data), 64'(e[OUT_W-1:0]));
                    chk("out_ovf", 64'(out_ovf), 64'(e[OUT_W]));
                end
                if (cnt_clr) mcnt = '0;
                else if (got && e[OUT_W] && mcnt != '1) mcnt = mcnt + CNT_W'(1);
                if (in_valid && in_ready) q.push_back(model(in_data, in_shift));
                stall     = out_valid && !out_ready;
                prev_data = out_data;
                prev_ovf  = out_ovf;
            end
        end
    endtask

    // Two back-to-back beats with out_ready high; checks 2-cycle latency and values
    task automatic pair2(input string name,
                         input logic [IN_W-1:0] d0, input logic [SH_W-1:0] s0,
                         input logic [OUT_W-1:0] x0, input logic o0,
                         input logic [IN_W-1:0] d1, input logic [SH_W-1:0] s1,
                         input logic [OUT_W-1:0] x1, input logic o1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d0; in_shift = s0;
        @(posedge clk); #1;
        in_data = d1; in_shift = s1;
        chk({name, "_lat"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, "_v0"}, 64'(out_valid), 64'(1));
        chk({name, "_d0"}, 64'(out_data), 64'(x0));
        chk({name, "_o0"}, 64'(out_ovf), 64'(o0));
        @(posedge clk); #1;
        chk({name, "_v1"}, 64'(out_valid), 64'(1));
        chk({name, "_d1"}, 64'(out_data), 64'(x1));
        chk({name, "_o1"}, 64'(out_ovf), 64'(o1));
        @(posedge clk); #1;
        chk({name, "_idle"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        int accepted;
        int cycles;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        fork
            monitor();
        join_none

        // Pin the model with hand-computed values
        chk("pin_18", 64'(model(16'h0018, 4'd4)), 64'(RND ? 13'h0002 : 13'h0001));
        chk("pin_ffe8", 64'(model(16'hFFE8, 4'd4)), 64'(RND ? 13'h0FFF : 13'h0FFE));
        chk("pin_7ff8", 64'(model(16'h7FF8, 4'd4)), 64'(RND ? 13'h17FF : 13'h07FF));
        chk("pin_8000", 64'(model(16'h8000, 4'd4)), 64'(13'h0800));
        chk("pin_1234", 64'(model(16'h1234, 4'd0)), 64'(13'h17FF));
        chk("pin_edcc", 64'(model(16'hEDCC, 4'd0)), 64'(13'h1800));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_data", 64'(out_data), 64'(0));
        chk("reset_out_ovf", 64'(out_ovf), 64'(0));
        chk("reset_ovf_cnt", 64'(ovf_cnt), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // T1 / T2 literal vectors
        pair2("t1", 16'h0018, 4'd4, RND ? 12'h002 : 12'h001, 1'b0,
                    16'hFFE8, 4'd4, RND ? 12'hFFF : 12'hFFE, 1'b0);
        pair2("t2", 16'h7FF8, 4'd4, 12'h7FF, RND,
                    16'h8000, 4'd4, 12'h800, 1'b0);

        // T3: counter from a clean start
        @(posedge clk); #1; cnt_clr = 1'b1;
        @(posedge clk); #1; cnt_clr = 1'b0;
        chk("t3_clr", 64'(ovf_cnt), 64'(0));
        pair2("t3", 16'h1234, 4'd0, 12'h7FF, 1'b1,
                    16'hEDCC, 4'd0, 12'h800, 1'b1);
        chk("t3_cnt", 64'(ovf_cnt), 64'(2));

        // T4: random valid/ready, 1000 accepted beats
        accepted = 0;
        cycles   = 0;
        @(posedge clk); #1;
        while (accepted < 1000 && cycles < 20000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = IN_W'($urandom());
            in_shift  = SH_W'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) accepted++;
            @(posedge clk); #1;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("t4_budget", 64'(accepted >= 1000), 64'(1));
        repeat (4) @(posedge clk);
        #1;
        chk("t4_drain", 64'(q.size()), 64'(0));

        // T5: saturate the counter, then clear on a saturated transfer
        in_valid = 1'b1; in_data = 16'h7FFF; in_shift = 4'd0;
        repeat (65541) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_sat", 64'(ovf_cnt), 64'(16'hFFFF));
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_pre_v", 64'(out_valid && out_ovf), 64'(1));
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("t5_clr", 64'(ovf_cnt), 64'(0));
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // T6: reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 16'h0100; in_shift = 4'd1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t6_full", 64'(in_ready), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'(0));
        chk("t6_rst_ready", 64'(in_ready), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("t6_no_stale", 64'(out_valid), 64'(0));
        end
        chk("t6_ovf_cnt", 64'(ovf_cnt), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
